vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port synchronous video RAM between the display fetch path and the JML-8 CPU write port.
//  - Display fetch (pixelgen character lookup) has absolute priority.
//  - CPU writes are buffered in a small FIFO and drained into RAM cycles the display leaves idle.
//  - Sits between the bus interface and the video RAM macro in jml-8-mini-vga.
// PARAMETERS
//  ADDR_BITS   12  VRAM address width; covers HTILES*VTILES character cells
//  DATA_BITS   8   character code width
//  FIFO_DEPTH  4   CPU write FIFO entries; power of two, >=2
// PORTS
//  clk           in   1          pixel clock, single clock domain
//  rst_n         in   1          asynchronous active-low reset
//  cpu_wr_valid  in   1          CPU write request
//  cpu_wr_ready  out  1          FIFO can accept; transfer when valid&&ready at posedge
//  cpu_addr      in   ADDR_BITS  CPU write address
//  cpu_data      in   DATA_BITS  CPU write data
//  disp_req      in   1          display fetch request, one-cycle pulse
//  disp_addr     in   ADDR_BITS  display fetch address, sampled with disp_req
//  disp_data     out  DATA_BITS  fetched character
//  disp_valid    out  1          disp_data valid, one-cycle pulse
//  ram_en        out  1          RAM access strobe
//  ram_we        out  1          1=write, 0=read; meaningful only with ram_en
//  ram_addr      out  ADDR_BITS  RAM address
//  ram_wdata     out  DATA_BITS  RAM write data
//  ram_rdata     in   DATA_BITS  RAM read data, valid one cycle after read strobe
// BEHAVIOUR
//  - Reset values: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, disp_data=0, disp_valid=0. FIFO emptied; cpu_wr_ready=1 once rst_n is high.
//  - All RAM-side outputs are registered. One access is issued per cycle.
//  - Grant FSM, evaluated every posedge:
//    - IDLE: no access.
//    - RD: disp_req sampled high; read disp_addr.
//    - WR: no disp_req and FIFO not empty; pop head, write it.
//    - Next state = RD if disp_req, else WR if !empty, else IDLE. Display always wins; a pending write waits.
//  - Display latency is fixed at 3 cycles: disp_req at edge N -> ram_en issued N+1 -> ram_rdata N+2 -> disp_data/disp_valid N+3.
//  - disp_req on consecutive cycles is legal. Each request yields exactly one disp_valid, in order.
//  - cpu_wr_ready = !full; it is computed from occupancy only, with no same-cycle pass-through when full.
//  - Push and pop in the same cycle: occupancy unchanged. Legal when full (pop frees, push is refused since ready=0).
//  - FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. full/empty come from MSB compare.
//  - Writes reach RAM in CPU issue order. A display read of an address still in the FIFO returns the old value; no forwarding.
//  - Reset mid-operation: pending writes are discarded, in-flight display read produces no disp_valid.
// CONFIGURATION
//  - VRAM_ARB_READBACK_EN defined: adds CPU readback ports.
//    - Ports: cpu_rd_valid(in,1), cpu_rd_ready(out,1), cpu_rd_addr(in,ADDR_BITS), cpu_rdata(out,DATA_BITS), cpu_rdata_valid(out,1).
//    - A readback is granted only when FIFO is empty and disp_req is low, preserving read-after-write order.
//    - cpu_rd_ready=1 only when IDLE would otherwise be chosen. cpu_rdata_valid follows 3 cycles after grant, same pipeline as display.
//    - Grant priority: display > write > readback.
//  - Not defined: these ports are absent and the FSM has no readback grant.
// STRUCTURE
//  - Shared constants go in vgaspecs.vh: HTILES, VTILES, VRAM_ADDR_BITS, grant-state encodings (IDLE=2'd0, RD=2'd1, WR=2'd2, RB=2'd3).
//  - One sub-module: vram_wr_fifo.
//    - Parameterised by width and depth; push/pop/full/empty interface; async active-low reset.
//    - Houses the pointer logic. Arbitration and read pipeline stay in vram_arbiter.
// TESTING
//  - Reset: hold rst_n=0 mid-stream -> all outputs 0, ram_en low, cpu_wr_ready=1 after release, no stale disp_valid.
//  - Single fetch: disp_req at cycle 10, addr 0x123, RAM model holds 0x41 -> ram_en/ram_we=1/0 @11, disp_valid=1, disp_data=0x41 @13 only.
//  - Write drain: 3 CPU writes (0x000<-0x01, 0x001<-0x02, 0x002<-0x03), disp_req low -> three ram_we pulses in order on consecutive cycles.
//  - Priority: FIFO holds 2 writes, disp_req high for 4 cycles -> 4 reads first, writes issue on cycles 5-6 of the burst window, order kept.
//  - Full: 4 writes with disp_req held high -> cpu_wr_ready=0 after 4th; 5th held. ready returns the cycle after first pop. No loss or duplication.
//  - Readback (macro on): write 0x055<-0xAA then read 0x055 -> cpu_rdata=0xAA. Read not granted before the write leaves the FIFO.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared VRAM geometry constants and grant-state encoding
package vram_arbiter_pkg;
  localparam int HTILES = 80;
  localparam int VTILES = 30;
  localparam int VRAM_ADDR_BITS = 12;
  localparam int VRAM_DATA_BITS = 8;
  localparam int WR_FIFO_DEPTH = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RB   = 2'd3
  } grant_e;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: CPU write, display fetch and RAM-side signals of the VRAM arbiter
// Readback signals exist only when VRAM_ARB_READBACK_EN is defined.
interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = VRAM_ADDR_BITS,
  parameter int DATA_BITS = VRAM_DATA_BITS
) ();
  logic                 cpu_wr_valid;
  logic                 cpu_wr_ready;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [DATA_BITS-1:0] cpu_data;
  logic                 disp_req;
  logic [ADDR_BITS-1:0] disp_addr;
  logic [DATA_BITS-1:0] disp_data;
  logic                 disp_valid;
  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [DATA_BITS-1:0] ram_wdata;
  logic [DATA_BITS-1:0] ram_rdata;
`ifdef VRAM_ARB_READBACK_EN
  logic                 cpu_rd_valid;
  logic                 cpu_rd_ready;
  logic [ADDR_BITS-1:0] cpu_rd_addr;
  logic [DATA_BITS-1:0] cpu_rdata;
  logic                 cpu_rdata_valid;
`endif
  modport master (
    output cpu_wr_valid, cpu_addr, cpu_data, disp_req, disp_addr, ram_rdata,
    input  cpu_wr_ready, disp_data, disp_valid, ram_en, ram_we, ram_addr, ram_wdata
`ifdef VRAM_ARB_READBACK_EN
    , output cpu_rd_valid, cpu_rd_addr
    , input  cpu_rd_ready, cpu_rdata, cpu_rdata_valid
`endif
  );
  modport slave (
    input  cpu_wr_valid, cpu_addr, cpu_data, disp_req, disp_addr, ram_rdata,
    output cpu_wr_ready, disp_data, disp_valid, ram_en, ram_we, ram_addr, ram_wdata
`ifdef VRAM_ARB_READBACK_EN
    , input  cpu_rd_valid, cpu_rd_addr
    , output cpu_rd_ready, cpu_rdata, cpu_rdata_valid
`endif
  );
endinterface

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: CPU write buffer, extra-MSB pointers give full/empty without a counter
module vram_wr_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM sharing, display fetch first, buffered CPU writes in idle slots
// Optional CPU readback path enabled by VRAM_ARB_READBACK_EN.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS  = VRAM_ADDR_BITS,
  parameter int DATA_BITS  = VRAM_DATA_BITS,
  parameter int FIFO_DEPTH = WR_FIFO_DEPTH
) (
  input logic           clk,
  input logic           rst_n,
  vram_arbiter_if.slave bus
);
  grant_e               state, nxt;
  logic                 full, empty, push, pop, rd_q, rb_go;
  logic [ADDR_BITS-1:0] head_addr, rb_addr;
  logic [DATA_BITS-1:0] head_data;
  assign bus.cpu_wr_ready = !full;
  assign push = bus.cpu_wr_valid && !full;
  assign pop  = !bus.disp_req && !empty;
  vram_wr_fifo #(.WIDTH(ADDR_BITS + DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  ({bus.cpu_addr, bus.cpu_data}),
    .pop  (pop),
    .dout ({head_addr, head_data}),
    .full (full),
    .empty(empty)
  );
`ifdef VRAM_ARB_READBACK_EN
  logic rb_q;
  // Readback only with the FIFO drained, so it always sees the CPU's own earlier writes
  assign bus.cpu_rd_ready = !bus.disp_req && empty;
  assign rb_go   = bus.cpu_rd_valid && bus.cpu_rd_ready;
  assign rb_addr = bus.cpu_rd_addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rb_q                <= 1'b0;
      bus.cpu_rdata_valid <= 1'b0;
      bus.cpu_rdata       <= '0;
    end else begin
      rb_q                <= state == RB;
      bus.cpu_rdata_valid <= rb_q;
      bus.cpu_rdata       <= rb_q ? bus.ram_rdata : bus.cpu_rdata;
    end
`else
  assign rb_go   = 1'b0;
  assign rb_addr = '0;
`endif
  assign nxt = bus.disp_req ? RD : !empty ? WR : rb_go ? RB : IDLE;
  // state tracks the access on the RAM bus; rd_q marks the cycle its read data appears
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      bus.ram_en     <= 1'b0;
      bus.ram_we     <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_wdata  <= '0;
      rd_q           <= 1'b0;
      bus.disp_valid <= 1'b0;
      bus.disp_data  <= '0;
    end else begin
      state          <= nxt;
      bus.ram_en     <= nxt != IDLE;
      bus.ram_we     <= nxt == WR;
      bus.ram_addr   <= nxt == RD ? bus.disp_addr : nxt == WR ? head_addr : nxt == RB ? rb_addr : bus.ram_addr;
      bus.ram_wdata  <= nxt == WR ? head_data : bus.ram_wdata;
      rd_q           <= state == RD;
      bus.disp_valid <= rd_q;
      bus.disp_data  <= rd_q ? bus.ram_rdata : bus.disp_data;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of fetch latency, write drain, priority, full FIFO and reset
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mem [4096];
  vram_arbiter_if bus();
  vram_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h123] = 8'h41;
    for (int i = 0; i < 4; i++) mem[12'h010 + i] = 8'h50 + 8'(i);
    mem[12'h055] = 8'h99;
    bus.cpu_wr_valid = 0; bus.cpu_addr = 0; bus.cpu_data = 0;
    bus.disp_req = 0; bus.disp_addr = 0;
`ifdef VRAM_ARB_READBACK_EN
    bus.cpu_rd_valid = 0; bus.cpu_rd_addr = 0;
`endif
    tick; tick;
    chk("reset_ram", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 32'h0);
    chk("reset_disp", {bus.disp_valid, bus.disp_data}, 32'h0);
    rst_n = 1'b1;
    tick;
    chk("reset_ready", bus.cpu_wr_ready, 32'h1);
    // single fetch
    bus.disp_req = 1; bus.disp_addr = 12'h123;
    tick;
    bus.disp_req = 0;
    chk("fetch_issue", {bus.ram_en, bus.ram_we, bus.ram_addr}, {18'h0, 1'b1, 1'b0, 12'h123});
    chk("fetch_nv1", bus.disp_valid, 32'h0);
    tick;
    chk("fetch_nv2", bus.disp_valid, 32'h0);
    tick;
    chk("fetch_data", {bus.disp_valid, bus.disp_data}, {23'h0, 1'b1, 8'h41});
    tick;
    chk("fetch_pulse", bus.disp_valid, 32'h0);
    // write drain
    bus.cpu_wr_valid = 1; bus.cpu_addr = 12'h000; bus.cpu_data = 8'h01;
    tick;
    bus.cpu_addr = 12'h001; bus.cpu_data = 8'h02;
    tick;
    chk("drain_w0", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, {10'h0, 2'b11, 12'h000, 8'h01});
    bus.cpu_addr = 12'h002; bus.cpu_data = 8'h03;
    tick;
    chk("drain_w1", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, {10'h0, 2'b11, 12'h001, 8'h02});
    bus.cpu_wr_valid = 0;
    tick;
    chk("drain_w2", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, {10'h0, 2'b11, 12'h002, 8'h03});
    tick;
    chk("drain_idle", bus.ram_en, 32'h0);
    chk("drain_mem", {mem[0], mem[1], mem[2]}, 32'h010203);
    // display priority over two pending writes
    bus.disp_req = 1; bus.disp_addr = 12'h010;
    bus.cpu_wr_valid = 1; bus.cpu_addr = 12'h020; bus.cpu_data = 8'hA1;
    tick;
    chk("prio_rd0", {bus.ram_en, bus.ram_we, bus.ram_addr}, {18'h0, 2'b10, 12'h010});
    bus.disp_addr = 12'h011; bus.cpu_addr = 12'h021; bus.cpu_data = 8'hA2;
    tick;
    chk("prio_rd1", {bus.ram_en, bus.ram_we, bus.ram_addr}, {18'h0, 2'b10, 12'h011});
    bus.cpu_wr_valid = 0; bus.disp_addr = 12'h012;
    tick;
    chk("prio_rd2", {bus.ram_en, bus.ram_we, bus.ram_addr}, {18'h0, 2'b10, 12'h012});
    chk("prio_dv0", {bus.disp_valid, bus.disp_data}, {23'h0, 1'b1, 8'h50});
    bus.disp_addr = 12'h013;
    tick;
    chk("prio_rd3", {bus.ram_en, bus.ram_we, bus.ram_addr}, {18'h0, 2'b10, 12'h013});
    chk("prio_dv1", {bus.disp_valid, bus.disp_data}, {23'h0, 1'b1, 8'h51});
    bus.disp_req = 0;
    tick;
    chk("prio_wr0", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, {10'h0, 2'b11, 12'h020, 8'hA1});
    chk("prio_dv2", {bus.disp_valid, bus.disp_data}, {23'h0, 1'b1, 8'h52});
    tick;
    chk("prio_wr1", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, {10'h0, 2'b11, 12'h021, 8'hA2});
    chk("prio_dv3", {bus.disp_valid, bus.disp_data}, {23'h0, 1'b1, 8'h53});
    tick;
    chk("prio_idle", {bus.ram_en, bus.disp_valid}, 32'h0);
    // fill the FIFO while the display holds the RAM
    bus.disp_req = 1; bus.disp_addr = 12'h030;
    bus.cpu_wr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.cpu_addr = 12'h100 + 12'(i); bus.cpu_data = 8'h11 + 8'(i);
      chk($sformatf("full_rdy%0d", i), bus.cpu_wr_ready, 32'h1);
      tick;
    end
    chk("full_ready0", bus.cpu_wr_ready, 32'h0);
    bus.cpu_addr = 12'h104; bus.cpu_data = 8'h15;
    tick;
    chk("full_held", bus.cpu_wr_ready, 32'h0);
    chk("full_noread_wr", bus.ram_we, 32'h0);
    bus.disp_req = 0;
    tick;
    chk("full_ready1", bus.cpu_wr_ready, 32'h1);
    chk("full_wr0", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, {10'h0, 2'b11, 12'h100, 8'h11});
    tick;
    bus.cpu_wr_valid = 0;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("full_wr%0d", i), {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata},
          {10'h0, 2'b11, 12'h100 + 12'(i), 8'h11 + 8'(i)});
      tick;
    end
    chk("full_idle", {bus.ram_en, bus.cpu_wr_ready}, 32'h1);
    repeat (3) tick;
    // reset with a pending write and a read in flight
    bus.disp_req = 1; bus.disp_addr = 12'h123;
    bus.cpu_wr_valid = 1; bus.cpu_addr = 12'h200; bus.cpu_data = 8'h77;
    tick;
    bus.disp_req = 0; bus.cpu_wr_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_ram", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 32'h0);
    chk("rst_disp", {bus.disp_valid, bus.disp_data}, 32'h0);
    tick;
    rst_n = 1'b1;
    chk("rst_ready", bus.cpu_wr_ready, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("rst_quiet%0d", i), {bus.ram_en, bus.disp_valid}, 32'h0);
    end
    chk("rst_discard", mem[12'h200], 32'h0);
`ifdef VRAM_ARB_READBACK_EN
    // readback waits until the write has drained
    bus.cpu_wr_valid = 1; bus.cpu_addr = 12'h055; bus.cpu_data = 8'hAA;
    tick;
    bus.cpu_wr_valid = 0;
    bus.cpu_rd_valid = 1; bus.cpu_rd_addr = 12'h055;
    chk("rb_blocked", bus.cpu_rd_ready, 32'h0);
    tick;
    chk("rb_after_wr", {bus.ram_we, bus.cpu_rd_ready}, 32'h3);
    tick;
    bus.cpu_rd_valid = 0;
    chk("rb_issue", {bus.ram_en, bus.ram_we, bus.ram_addr}, {18'h0, 2'b10, 12'h055});
    tick;
    chk("rb_nv", bus.cpu_rdata_valid, 32'h0);
    tick;
    chk("rb_data", {bus.cpu_rdata_valid, bus.cpu_rdata}, {23'h0, 1'b1, 8'hAA});
    chk("rb_no_disp", bus.disp_valid, 32'h0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
